// File: rtl/gen_gamma_stream_coder.sv
// +--------------------------------------------------------------------------+
// | gen_gamma_stream_coder                                                    |
// | Streaming gamma coder: buffers noise keys in a FIFO and mixes one key     |
// | into each handshaked data word (add to encode, subtract to decode).       |
// | Optional feature macro: GAMMA_KEY_WHITEN_EN (XOR-whitened key storage).   |
// | Revision: 1.0 - initial streaming release                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module gen_gamma_stream_coder #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SIZE-1:0]  noise,
  input  logic             noise_vld,
  input  logic             dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE:0]    in_data,
  input  logic [SIZE-1:0]  in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE:0]    out_data,
  output logic [SIZE-1:0]  out_key,
  output logic             key_empty,
  output logic             key_full,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int              c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_full = (c_aw+1)'(DEPTH);

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;

  logic            w_wr;
  logic            w_pop;
  logic            w_acc;
  logic [SIZE-1:0] w_key;
  logic [SIZE-1:0] w_store;
  logic [SIZE:0]   w_ext_key;
  logic [SIZE:0]   w_mix;

  assign key_empty = (r_count == '0);
  assign key_full  = (r_count == c_full);
  assign w_wr      = en && noise_vld && !key_full;

  assign in_ready  = (!out_valid || out_ready) && (dec || !key_empty);
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = w_acc && !dec;

  assign w_key     = dec ? in_key : r_mem[r_rd_ptr];
  assign w_ext_key = {1'b0, w_key};
  // Encode ignores in_data[SIZE]; the carry of the add lands in bit SIZE.
  assign w_mix     = dec ? (in_data - w_ext_key)
                         : ({1'b0, in_data[SIZE-1:0]} + w_ext_key);

`ifdef GAMMA_KEY_WHITEN_EN
  logic [SIZE-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
    end else if (w_wr) begin
      r_prev <= noise;
    end
  end

  assign w_store = noise ^ r_prev;
`else
  assign w_store = noise;
`endif

  // Storage is not reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_store;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_key   <= '0;
      word_cnt  <= '0;
    end else begin
      if (w_acc) begin
        out_valid <= 1'b1;
        out_data  <= w_mix;
        out_key   <= w_key;
        word_cnt  <= word_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gen_gamma_stream_coder.sv
// Testbench for gen_gamma_stream_coder: directed scenarios plus random traffic,
// checked by a queue-based key model and an output scoreboard.
`default_nettype none

module tb_gen_gamma_stream_coder;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [SIZE-1:0]  noise;
  logic             noise_vld;
  logic             dec;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE:0]    in_data;
  logic [SIZE-1:0]  in_key;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE:0]    out_data;
  logic [SIZE-1:0]  out_key;
  logic             key_empty;
  logic             key_full;
  logic [CNT_W-1:0] word_cnt;

  gen_gamma_stream_coder #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .noise(noise), .noise_vld(noise_vld),
    .dec(dec), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_key(out_key), .key_empty(key_empty),
    .key_full(key_full), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SIZE:0]   d;
    logic [SIZE-1:0] k;
  } exp_t;

  exp_t             sb[$];
  logic [SIZE-1:0]  kq[$];
  logic             m_ov;
  logic [CNT_W-1:0] m_cnt;
  logic [SIZE-1:0]  m_prev;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%h key=%h, required no output", out_data, out_key);
      end else begin
        if (out_data !== sb[0].d || out_key !== sb[0].k) begin
          errors++;
          $display("FAIL out_word: got data=%h key=%h, required data=%h key=%h",
                   out_data, out_key, sb[0].d, sb[0].k);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus: check observable state, advance the reference model.
  task automatic tick();
    logic          rdy;
    logic          full;
    logic [SIZE-1:0] k;
    exp_t          e;
    @(negedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    chk("key_empty", 32'(key_empty), 32'(kq.size() == 0));
    chk("key_full", 32'(key_full), 32'(kq.size() == DEPTH));
    rdy  = (!m_ov || out_ready) && (dec || kq.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    full = (kq.size() == DEPTH);
    if (in_valid && rdy) begin
      if (dec) begin
        k   = in_key;
        e.d = in_data - {1'b0, k};
      end else begin
        k   = kq.pop_front();
        e.d = {1'b0, in_data[SIZE-1:0]} + {1'b0, k};
      end
      e.k = k;
      sb.push_back(e);
      m_cnt = m_cnt + 1'b1;
      m_ov  = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (en && noise_vld && !full) begin
`ifdef GAMMA_KEY_WHITEN_EN
      kq.push_back(noise ^ m_prev);
      m_prev = noise;
`else
      kq.push_back(noise);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; noise_vld = 1'b0; noise = '0; dec = 1'b0;
    in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
  endtask

  task automatic push_key(input logic [SIZE-1:0] n);
    en = 1'b1; noise_vld = 1'b1; noise = n;
    tick();
    en = 1'b0; noise_vld = 1'b0;
  endtask

  task automatic model_reset();
    kq.delete(); sb.delete();
    m_ov = 1'b0; m_cnt = '0; m_prev = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SIZE-1:0] wkey2;
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_key_empty", 32'(key_empty), 32'd1);
    chk("rst_key_full", 32'(key_full), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Basic encode with carry into bit SIZE.
    push_key(8'h5A);
    in_valid = 1'b1; in_data = 9'h0C0; dec = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("enc1_data", 32'(out_data), 32'h11A);
    chk("enc1_key", 32'(out_key), 32'h5A);
    chk("enc1_cnt", 32'(word_cnt), 32'd1);
    chk("enc1_empty", 32'(key_empty), 32'd1);
    tick();

    // Encode/decode round trip.
    push_key(8'h01);
    in_valid = 1'b1; in_data = 9'h0FF;
    tick();
`ifndef GAMMA_KEY_WHITEN_EN
    chk("enc2_data", 32'(out_data), 32'h100);
`endif
    dec = 1'b1; in_data = 9'h100; in_key = 8'h01;
    tick();
    chk("dec2_data", 32'(out_data), 32'h0FF);
    in_valid = 1'b0; dec = 1'b0;
    tick();

    // Fill, overflow drop, then drain in order.
    push_key(8'h11); push_key(8'h22); push_key(8'h33); push_key(8'h44);
    push_key(8'h55);
    chk("fill_full", 32'(key_full), 32'd1);
    in_valid = 1'b1; in_data = 9'h000;
    repeat (4) tick();
    in_valid = 1'b0;
    tick();

    // Output hold under back-pressure.
    push_key(8'h77); push_key(8'h66);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 9'h003;
    tick();
    in_data = 9'h004;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // Key starvation, then a late key arrives.
    in_valid = 1'b1; in_data = 9'h0AA; dec = 1'b0;
    repeat (3) tick();
    en = 1'b1; noise_vld = 1'b1; noise = 8'h3C;
    tick();
    en = 1'b0; noise_vld = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    push_key(8'h01); push_key(8'h02); push_key(8'h03);
    in_valid = 1'b1; in_data = 9'h010;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_key_empty", 32'(key_empty), 32'd1);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Key storage after reset: whitened keys chain through the previous raw word.
    push_key(8'h0F); push_key(8'hF0);
`ifdef GAMMA_KEY_WHITEN_EN
    wkey2 = 8'hFF;
`else
    wkey2 = 8'hF0;
`endif
    in_valid = 1'b1; in_data = 9'h000;
    tick();
    chk("wht_key1", 32'(out_key), 32'h0F);
    tick();
    chk("wht_key2", 32'(out_key), 32'(wkey2));
    in_valid = 1'b0;
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      noise_vld = $urandom_range(0, 1);
      noise     = SIZE'($urandom);
      dec       = ($urandom_range(0, 3) == 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = (SIZE+1)'($urandom);
      in_key    = SIZE'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    idle();
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
